// File: rtl/add_sub_pkg.sv
// Shared types, constants and helpers for the pipelined adder/subtractor.
package add_sub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Flags produced by the most significant slice.
    typedef struct packed {
        logic cout;
        logic ovf;
    } add_res_t;

    // Bits handled by each pipeline slice.
    function automatic int unsigned slice_w(int unsigned width, int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SW-bit ripple of full-adder cells.
module add_slice #(
    parameter int unsigned SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] bx,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    logic [SW:0] w_c;

    // Ripple chain: w_c[i] is the carry into bit i.
    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < SW; i++) begin
            s[i]     = a[i] ^ bx[i] ^ w_c[i];
            w_c[i+1] = (a[i] & bx[i]) | (w_c[i] & (a[i] ^ bx[i]));
        end
    end

    assign co       = w_c[SW];
    assign c_msb_in = w_c[SW-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one ripple slice per stage, carry
// registered between stages, operand skew and result deskew so all bits of an
// operation leave together. Valid/ready handshake with full backpressure.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SW = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gen_param_err
        $error("add_sub_pipe: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;
    logic [STAGES-1:0] r_vld;

    // Whole pipeline moves together unless the output is stalled.
    assign w_adv     = !r_vld[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES-1];

    assign w_bx = (sub == ADD) ? b : ~b;
    assign w_c0 = (sub == ADD) ? cin : ~cin;

    // Per-stage valid bits shift with the pipeline; bubbles travel as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        // Operand bits above slice k that later slices still need.
        localparam int unsigned HI = WIDTH - (k + 1) * SW;

        logic [SW-1:0]         w_a;
        logic [SW-1:0]         w_b;
        logic [SW-1:0]         w_s;
        logic                  w_ci;
        logic                  w_co;
        logic                  w_cm;
        logic [(k+1)*SW-1:0]   w_sum_nxt;
        logic [(k+1)*SW-1:0]   r_sum;

        if (k == 0) begin : gen_first
            assign w_a       = a[SW-1:0];
            assign w_b       = w_bx[SW-1:0];
            assign w_ci      = w_c0;
            assign w_sum_nxt = w_s;
        end else begin : gen_next
            assign w_a       = gen_stage[k-1].gen_skew.r_a[SW-1:0];
            assign w_b       = gen_stage[k-1].gen_skew.r_bx[SW-1:0];
            assign w_ci      = gen_stage[k-1].gen_skew.r_c;
            assign w_sum_nxt = {w_s, gen_stage[k-1].r_sum};
        end

        add_slice #(
            .SW(SW)
        ) u_slice (
            .a        (w_a),
            .bx       (w_b),
            .ci       (w_ci),
            .s        (w_s),
            .co       (w_co),
            .c_msb_in (w_cm)
        );

        // Partial result: low bits finished so far, deskewed toward the output.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum <= '0;
            end else if (w_adv) begin
                r_sum <= w_sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : gen_skew
            logic [HI-1:0] w_a_up;
            logic [HI-1:0] w_b_up;
            logic [HI-1:0] r_a;
            logic [HI-1:0] r_bx;
            logic          r_c;

            if (k == 0) begin : gen_src_in
                assign w_a_up = a[WIDTH-1:SW];
                assign w_b_up = w_bx[WIDTH-1:SW];
            end else begin : gen_src_prev
                assign w_a_up = gen_stage[k-1].gen_skew.r_a[HI+SW-1:SW];
                assign w_b_up = gen_stage[k-1].gen_skew.r_bx[HI+SW-1:SW];
            end

            // Operand skew and inter-slice carry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a  <= '0;
                    r_bx <= '0;
                    r_c  <= 1'b0;
                end else if (w_adv) begin
                    r_a  <= w_a_up;
                    r_bx <= w_b_up;
                    r_c  <= w_co;
                end
            end
        end else begin : gen_last
            add_res_t r_res;

            // Final carry and signed overflow from the top slice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res.cout <= w_co;
                    r_res.ovf  <= w_co ^ w_cm;
                end
            end
        end
    end

    assign sum  = gen_stage[STAGES-1].r_sum;
    assign cout = gen_stage[STAGES-1].gen_last.r_res.cout;
    assign ovf  = gen_stage[STAGES-1].gen_last.r_res.ovf;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=8, STAGES=2).
module tb_add_sub_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    add_sub_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
        int           stl;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           stl = 0;
    logic [W-1:0] exp_s = '0;
    logic         exp_c = 1'b0;
    logic         exp_o = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mc, input logic ms);
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        bx   = ms ? ~mb : mb;
        c0   = ms ? ~mc : mc;
        full = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, c0};
        low  = {1'b0, ma[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, c0};
        return {low[W-1] ^ full[W], full[W], full[W-1:0]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) stl <= 0;
        else if (out_valid && !out_ready) stl <= stl + 1;
    end

    // Push the expected response at each acceptance.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            q.push_back('{s: exp_s, c: exp_c, o: exp_o, cyc: cyc, stl: stl});
        end
    end

    // Pop and compare at each delivery.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got sum=%0h with no operation pending", sum);
            end else begin
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.o));
                check("latency", 32'(cyc - e.cyc), 32'(S + (stl - e.stl)));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
        logic acc;
        acc      = 1'b0;
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        exp_s    = es;
        exp_c    = ec;
        exp_o    = eo;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            acc = in_ready;
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 200 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] snap_s;
        logic         snap_c;
        logic         snap_o;
        logic         snap_v;
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: a, b, cin, sub -> sum, cout, ovf.
        send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        send(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
        send(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        send(8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        drain();

        // Backpressure: four back-to-back ops, 3-cycle stall at first result.
        fork
            begin
                send(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
                send(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
                send(8'h20, 8'h30, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
                send(8'hF0, 8'h20, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
            end
            begin
                for (int n = 0; n < 20 && !out_valid; n++) begin
                    @(posedge clk);
                    #1;
                end
                check("bp_first_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                snap_s = sum;
                snap_c = cout;
                snap_o = ovf;
                snap_v = out_valid;
                for (int n = 0; n < 3; n++) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'(snap_v));
                    check("stall_sum", 32'(sum), 32'(snap_s));
                    check("stall_cout", 32'(cout), 32'(snap_c));
                    check("stall_ovf", 32'(ovf), 32'(snap_o));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight.
        send(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
        send(8'h44, 8'h11, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            ra        = W'($urandom);
            rb        = W'($urandom);
            rc        = 1'($urandom);
            rs        = 1'($urandom);
            m         = model(ra, rb, rc, rs);
            a         = ra;
            b         = rb;
            cin       = rc;
            sub       = rs;
            exp_s     = m[W-1:0];
            exp_c     = m[W];
            exp_o     = m[W+1];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
